// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I decode definitions for the ID stage.
// Contents:
//   - major opcode constants
//   - alu_op_e   : ALU operation selected in EX
//   - wb_sel_e   : writeback source (ALU result, load data, PC+4)
//   - imm_type_e : which immediate format the instruction uses
//   - ctrl_t     : control fields carried through the ID/EX register
//   - alu_from_funct3 / ctrl_squash helpers
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd5
  } imm_type_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src_pc;
    logic    alu_src_imm;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    wb_sel_e wb_sel;
    logic    branch;
    logic    jal;
    logic    jalr;
  } ctrl_t;

  // alt selects SUB (funct3 000) or SRA (funct3 101); callers gate it
  // according to whether instr[30] is meaningful for the opcode.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Clear every field that has an architectural side effect so an
  // invalid slot can never write a register, touch memory or redirect.
  function automatic ctrl_t ctrl_squash(input ctrl_t c);
    ctrl_t r;
    r           = c;
    r.mem_read  = 1'b0;
    r.mem_write = 1'b0;
    r.reg_write = 1'b0;
    r.branch    = 1'b0;
    r.jal       = 1'b0;
    r.jalr      = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/decode_ctrl.sv
// decode_ctrl: combinational RV32I control decoder.
// Ports:
//   opcode    in  7  instr[6:0]
//   funct3    in  3  instr[14:12]
//   funct7_5  in  1  instr[30] (SUB / SRA select)
//   ctrl      out    ctrl_t control bundle (reg_write not yet masked for rd = x0)
//   imm_type  out    immediate format
//   rs1_used  out 1  instruction reads rs1
//   rs2_used  out 1  instruction reads rs2
//   illegal   out 1  opcode not recognised
module decode_ctrl
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output ctrl_t      ctrl,
  output imm_type_e  imm_type,
  output logic       rs1_used,
  output logic       rs2_used,
  output logic       illegal
);

  always_comb begin
    ctrl     = '0;
    imm_type = IMM_NONE;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OPC_LUI: begin
        imm_type         = IMM_U;
        ctrl.alu_op      = ALU_PASSB;
        ctrl.alu_src_imm = 1'b1;
        ctrl.reg_write   = 1'b1;
      end
      OPC_AUIPC: begin
        imm_type         = IMM_U;
        ctrl.alu_src_pc  = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.reg_write   = 1'b1;
      end
      OPC_JAL: begin
        // ALU forms the target PC+imm; rd receives PC+4.
        imm_type         = IMM_J;
        ctrl.alu_src_pc  = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.reg_write   = 1'b1;
        ctrl.wb_sel      = WB_PC4;
        ctrl.jal         = 1'b1;
      end
      OPC_JALR: begin
        imm_type         = IMM_I;
        rs1_used         = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.reg_write   = 1'b1;
        ctrl.wb_sel      = WB_PC4;
        ctrl.jalr        = 1'b1;
      end
      OPC_BRANCH: begin
        // Comparison itself is chosen in EX from funct3.
        imm_type    = IMM_B;
        rs1_used    = 1'b1;
        rs2_used    = 1'b1;
        ctrl.alu_op = ALU_SUB;
        ctrl.branch = 1'b1;
      end
      OPC_LOAD: begin
        imm_type         = IMM_I;
        rs1_used         = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.mem_read    = 1'b1;
        ctrl.reg_write   = 1'b1;
        ctrl.wb_sel      = WB_MEM;
      end
      OPC_STORE: begin
        imm_type         = IMM_S;
        rs1_used         = 1'b1;
        rs2_used         = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.mem_write   = 1'b1;
      end
      OPC_OP_IMM: begin
        // instr[30] is part of the immediate except for the shift-right pair.
        imm_type         = IMM_I;
        rs1_used         = 1'b1;
        ctrl.alu_op      = alu_from_funct3(funct3, funct7_5 && (funct3 == 3'b101));
        ctrl.alu_src_imm = 1'b1;
        ctrl.reg_write   = 1'b1;
      end
      OPC_OP: begin
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
        ctrl.alu_op    = alu_from_funct3(funct3, funct7_5);
        ctrl.reg_write = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: begin
        // Treated as a valid NOP.
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I instruction-decode stage with ID/EX pipeline register.
// Ports:
//   clk, reset_n                   clock, async active-low reset
//   if_id_valid/instr/pc           instruction from IF/ID
//   rs1_addr, rs2_addr      out    register file read addresses (combinational)
//   rs1_data, rs2_data      in     register file read data
//   wb_wr_en/rd_addr/wr_data in    same-cycle writeback, bypassed into operands
//   ex_stall_i              in     downstream hold
//   flush_i                 in     kill ID contents (taken branch/jump in EX)
//   stall_o                 out    hold PC and IF/ID (combinational)
//   id_ex_*                 out    registered decode results for EX
module id_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            if_id_valid,
  input  logic [31:0]     if_id_instr,
  input  logic [XLEN-1:0] if_id_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            wb_wr_en,
  input  logic [4:0]      wb_rd_addr,
  input  logic [XLEN-1:0] wb_wr_data,
  input  logic            ex_stall_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            id_ex_valid,
  output logic [XLEN-1:0] id_ex_pc,
  output logic [XLEN-1:0] id_ex_rs1_val,
  output logic [XLEN-1:0] id_ex_rs2_val,
  output logic [XLEN-1:0] id_ex_imm,
  output logic [4:0]      id_ex_rs1_addr,
  output logic [4:0]      id_ex_rs2_addr,
  output logic [4:0]      id_ex_rd,
  output logic [2:0]      id_ex_funct3,
  output logic [3:0]      id_ex_alu_op,
  output logic            id_ex_alu_src_pc,
  output logic            id_ex_alu_src_imm,
  output logic            id_ex_mem_read,
  output logic            id_ex_mem_write,
  output logic            id_ex_reg_write,
  output logic [1:0]      id_ex_wb_sel,
  output logic            id_ex_branch,
  output logic            id_ex_jal,
  output logic            id_ex_jalr,
  output logic            id_ex_illegal
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    ctrl_t           ctrl;
    logic            illegal;
  } id_ex_t;

  function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] ins, input imm_type_e t);
    logic [XLEN-1:0] imm;
    case (t)
      IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   imm = {ins[31:12], 12'h000};
      IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  ctrl_t           dec_ctrl;
  imm_type_e       dec_imm_type;
  logic            dec_rs1_used;
  logic            dec_rs2_used;
  logic            dec_illegal;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic            load_use;
  id_ex_t          id_ex_d;
  id_ex_t          id_ex_q;

  // ---- ID: decode, operand bypass, hazard detection ----
  decode_ctrl u_decode_ctrl (
    .opcode   (if_id_instr[6:0]),
    .funct3   (if_id_instr[14:12]),
    .funct7_5 (if_id_instr[30]),
    .ctrl     (dec_ctrl),
    .imm_type (dec_imm_type),
    .rs1_used (dec_rs1_used),
    .rs2_used (dec_rs2_used),
    .illegal  (dec_illegal)
  );

  assign rs1_addr = if_id_instr[19:15];
  assign rs2_addr = if_id_instr[24:20];

  // The register file writes on the same edge we capture, so its read
  // port still shows the old value; steer the writeback data in instead.
  assign rs1_fwd = (wb_wr_en && (wb_rd_addr != 5'd0) && (wb_rd_addr == rs1_addr)) ? wb_wr_data : rs1_data;
  assign rs2_fwd = (wb_wr_en && (wb_rd_addr != 5'd0) && (wb_rd_addr == rs2_addr)) ? wb_wr_data : rs2_data;

  assign load_use = if_id_valid && id_ex_q.valid && id_ex_q.ctrl.mem_read &&
                    (id_ex_q.rd != 5'd0) &&
                    ((dec_rs1_used && (id_ex_q.rd == rs1_addr)) ||
                     (dec_rs2_used && (id_ex_q.rd == rs2_addr)));

  assign stall_o = (ex_stall_i || load_use) && !flush_i;

  always_comb begin
    id_ex_d = id_ex_q;
    if (flush_i || (!ex_stall_i && load_use)) begin
      // Kill or bubble: slot becomes invalid and side-effect free.
      id_ex_d.valid   = 1'b0;
      id_ex_d.ctrl    = ctrl_squash(id_ex_q.ctrl);
      id_ex_d.illegal = 1'b0;
    end else if (!ex_stall_i) begin
      id_ex_d.valid    = if_id_valid;
      id_ex_d.pc       = if_id_pc;
      id_ex_d.rs1_val  = rs1_fwd;
      id_ex_d.rs2_val  = rs2_fwd;
      id_ex_d.imm      = gen_imm(if_id_instr, dec_imm_type);
      id_ex_d.rs1_addr = rs1_addr;
      id_ex_d.rs2_addr = rs2_addr;
      id_ex_d.rd       = if_id_instr[11:7];
      id_ex_d.funct3   = if_id_instr[14:12];
      id_ex_d.ctrl     = dec_ctrl;
      id_ex_d.illegal  = dec_illegal;
      if (if_id_instr[11:7] == 5'd0) id_ex_d.ctrl.reg_write = 1'b0;
      if (!if_id_valid) begin
        id_ex_d.ctrl    = ctrl_squash(dec_ctrl);
        id_ex_d.illegal = 1'b0;
      end
    end
  end

  // ---- ID/EX pipeline register ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      id_ex_q    <= '0;
      id_ex_q.pc <= RESET_PC;
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  assign id_ex_valid       = id_ex_q.valid;
  assign id_ex_pc          = id_ex_q.pc;
  assign id_ex_rs1_val     = id_ex_q.rs1_val;
  assign id_ex_rs2_val     = id_ex_q.rs2_val;
  assign id_ex_imm         = id_ex_q.imm;
  assign id_ex_rs1_addr    = id_ex_q.rs1_addr;
  assign id_ex_rs2_addr    = id_ex_q.rs2_addr;
  assign id_ex_rd          = id_ex_q.rd;
  assign id_ex_funct3      = id_ex_q.funct3;
  assign id_ex_alu_op      = id_ex_q.ctrl.alu_op;
  assign id_ex_alu_src_pc  = id_ex_q.ctrl.alu_src_pc;
  assign id_ex_alu_src_imm = id_ex_q.ctrl.alu_src_imm;
  assign id_ex_mem_read    = id_ex_q.ctrl.mem_read;
  assign id_ex_mem_write   = id_ex_q.ctrl.mem_write;
  assign id_ex_reg_write   = id_ex_q.ctrl.reg_write;
  assign id_ex_wb_sel      = id_ex_q.ctrl.wb_sel;
  assign id_ex_branch      = id_ex_q.ctrl.branch;
  assign id_ex_jal         = id_ex_q.ctrl.jal;
  assign id_ex_jalr        = id_ex_q.ctrl.jalr;
  assign id_ex_illegal     = id_ex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed scenarios plus randomized traffic for id_stage,
// compared cycle by cycle against a behavioural ID/EX model.
module tb_id_stage;
  import riscv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        if_id_valid = 1'b0;
  logic [31:0] if_id_instr = 32'h0;
  logic [31:0] if_id_pc = 32'h0;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data = 32'h0, rs2_data = 32'h0;
  logic        wb_wr_en = 1'b0;
  logic [4:0]  wb_rd_addr = 5'd0;
  logic [31:0] wb_wr_data = 32'h0;
  logic        ex_stall_i = 1'b0, flush_i = 1'b0;
  logic        stall_o;
  logic        id_ex_valid;
  logic [31:0] id_ex_pc, id_ex_rs1_val, id_ex_rs2_val, id_ex_imm;
  logic [4:0]  id_ex_rs1_addr, id_ex_rs2_addr, id_ex_rd;
  logic [2:0]  id_ex_funct3;
  logic [3:0]  id_ex_alu_op;
  logic        id_ex_alu_src_pc, id_ex_alu_src_imm, id_ex_mem_read, id_ex_mem_write;
  logic        id_ex_reg_write;
  logic [1:0]  id_ex_wb_sel;
  logic        id_ex_branch, id_ex_jal, id_ex_jalr, id_ex_illegal;

  int n_checks = 0;
  int n_pass   = 0;

  id_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_wr_en(wb_wr_en), .wb_rd_addr(wb_rd_addr), .wb_wr_data(wb_wr_data),
    .ex_stall_i(ex_stall_i), .flush_i(flush_i), .stall_o(stall_o),
    .id_ex_valid(id_ex_valid), .id_ex_pc(id_ex_pc),
    .id_ex_rs1_val(id_ex_rs1_val), .id_ex_rs2_val(id_ex_rs2_val), .id_ex_imm(id_ex_imm),
    .id_ex_rs1_addr(id_ex_rs1_addr), .id_ex_rs2_addr(id_ex_rs2_addr), .id_ex_rd(id_ex_rd),
    .id_ex_funct3(id_ex_funct3), .id_ex_alu_op(id_ex_alu_op),
    .id_ex_alu_src_pc(id_ex_alu_src_pc), .id_ex_alu_src_imm(id_ex_alu_src_imm),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_mem_write(id_ex_mem_write),
    .id_ex_reg_write(id_ex_reg_write), .id_ex_wb_sel(id_ex_wb_sel),
    .id_ex_branch(id_ex_branch), .id_ex_jal(id_ex_jal), .id_ex_jalr(id_ex_jalr),
    .id_ex_illegal(id_ex_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Expected contents of the ID/EX register.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, a, b, imm;
    logic [4:0]  ra, rb, rd;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic        spc, simm, mr, mw, rw;
    logic [1:0]  wb;
    logic        br, jal, jalr, ill;
  } exp_t;

  exp_t m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic exp_t rst_exp();
    exp_t e;
    e    = '0;
    e.pc = RST_PC;
    return e;
  endfunction

  function automatic exp_t quiet(input exp_t e0);
    exp_t e;
    e = e0;
    e.valid = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.rw = 1'b0;
    e.br = 1'b0; e.jal = 1'b0; e.jalr = 1'b0; e.ill = 1'b0;
    return e;
  endfunction

  // Immediates written as arithmetic on the encoded fields.
  function automatic logic [31:0] imm_i(input logic [31:0] ins);
    return 32'($signed(ins) >>> 20);
  endfunction
  function automatic logic [31:0] imm_s(input logic [31:0] ins);
    return (32'($signed(ins) >>> 20) & ~32'd31) | {27'd0, ins[11:7]};
  endfunction
  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    int v;
    v = ins[31] ? -4096 : 0;
    v += int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
    return 32'(v);
  endfunction
  function automatic logic [31:0] imm_j(input logic [31:0] ins);
    int v;
    v = ins[31] ? -(1 << 20) : 0;
    v += int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
    return 32'(v);
  endfunction

  function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0: return alt ? 4'(ALU_SUB) : 4'(ALU_ADD);
      3'd1: return 4'(ALU_SLL);
      3'd2: return 4'(ALU_SLT);
      3'd3: return 4'(ALU_SLTU);
      3'd4: return 4'(ALU_XOR);
      3'd5: return alt ? 4'(ALU_SRA) : 4'(ALU_SRL);
      3'd6: return 4'(ALU_OR);
      default: return 4'(ALU_AND);
    endcase
  endfunction

  function automatic logic ref_load_use();
    logic [6:0] opc;
    logic u1, u2;
    opc = if_id_instr[6:0];
    u1 = opc inside {OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP};
    u2 = opc inside {OPC_BRANCH, OPC_STORE, OPC_OP};
    return if_id_valid && m.valid && m.mr && (m.rd != 5'd0) &&
           ((u1 && m.rd == if_id_instr[19:15]) || (u2 && m.rd == if_id_instr[24:20]));
  endfunction

  function automatic exp_t ref_capture();
    exp_t e;
    logic [31:0] ins;
    ins = if_id_instr;
    e = '0;
    e.pc = if_id_pc;
    e.ra = ins[19:15]; e.rb = ins[24:20]; e.rd = ins[11:7]; e.f3 = ins[14:12];
    e.a = (wb_wr_en && wb_rd_addr != 0 && wb_rd_addr == e.ra) ? wb_wr_data : rs1_data;
    e.b = (wb_wr_en && wb_rd_addr != 0 && wb_rd_addr == e.rb) ? wb_wr_data : rs2_data;
    case (ins[6:0])
      OPC_LUI:    begin e.imm = ins & 32'hFFFF_F000; e.alu = 4'(ALU_PASSB); e.simm = 1; e.rw = 1; end
      OPC_AUIPC:  begin e.imm = ins & 32'hFFFF_F000; e.spc = 1; e.simm = 1; e.rw = 1; end
      OPC_JAL:    begin e.imm = imm_j(ins); e.spc = 1; e.simm = 1; e.rw = 1; e.wb = 2; e.jal = 1; end
      OPC_JALR:   begin e.imm = imm_i(ins); e.simm = 1; e.rw = 1; e.wb = 2; e.jalr = 1; end
      OPC_BRANCH: begin e.imm = imm_b(ins); e.alu = 4'(ALU_SUB); e.br = 1; end
      OPC_LOAD:   begin e.imm = imm_i(ins); e.simm = 1; e.mr = 1; e.rw = 1; e.wb = 1; end
      OPC_STORE:  begin e.imm = imm_s(ins); e.simm = 1; e.mw = 1; end
      OPC_OP_IMM: begin
        e.imm = imm_i(ins); e.simm = 1; e.rw = 1;
        e.alu = ref_alu(e.f3, ins[30] && e.f3 == 3'd5);
      end
      OPC_OP:     begin e.rw = 1; e.alu = ref_alu(e.f3, ins[30]); end
      OPC_FENCE, OPC_SYSTEM: ;
      default:    e.ill = 1;
    endcase
    if (e.rd == 5'd0) e.rw = 1'b0;
    e.valid = if_id_valid;
    if (!if_id_valid) e = quiet(e);
    return e;
  endfunction

  task automatic compare_all();
    chk("valid", id_ex_valid, m.valid);
    if (m.valid) begin
      chk("pc", id_ex_pc, m.pc);
      chk("rs1_val", id_ex_rs1_val, m.a);
      chk("rs2_val", id_ex_rs2_val, m.b);
      chk("imm", id_ex_imm, m.imm);
      chk("rs1_addr_q", id_ex_rs1_addr, m.ra);
      chk("rs2_addr_q", id_ex_rs2_addr, m.rb);
      chk("rd", id_ex_rd, m.rd);
      chk("funct3", id_ex_funct3, m.f3);
      chk("alu_op", id_ex_alu_op, m.alu);
      chk("src_pc", id_ex_alu_src_pc, m.spc);
      chk("src_imm", id_ex_alu_src_imm, m.simm);
      chk("wb_sel", id_ex_wb_sel, m.wb);
      chk("illegal", id_ex_illegal, m.ill);
    end
    chk("mem_read", id_ex_mem_read, m.mr);
    chk("mem_write", id_ex_mem_write, m.mw);
    chk("reg_write", id_ex_reg_write, m.rw);
    chk("branch", id_ex_branch, m.br);
    chk("jal", id_ex_jal, m.jal);
    chk("jalr", id_ex_jalr, m.jalr);
  endtask

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic step();
    exp_t nx;
    logic lu;
    #3;
    chk("rs1_addr", rs1_addr, if_id_instr[19:15]);
    chk("rs2_addr", rs2_addr, if_id_instr[24:20]);
    lu = ref_load_use();
    chk("stall_o", stall_o, (ex_stall_i || lu) && !flush_i);
    nx = m;
    if (flush_i) nx = quiet(m);
    else if (ex_stall_i) nx = m;
    else if (lu) nx = quiet(m);
    else nx = ref_capture();
    @(posedge clk);
    m = nx;
    #1;
    compare_all();
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    if_id_valid = 1'b1; if_id_instr = ins; if_id_pc = pc;
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STORE};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OPC_BRANCH};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 12))
      0: r[6:0] = OPC_LUI;     1: r[6:0] = OPC_AUIPC;   2: r[6:0] = OPC_JAL;
      3: r[6:0] = OPC_JALR;    4: r[6:0] = OPC_BRANCH;  5, 6: r[6:0] = OPC_LOAD;
      7: r[6:0] = OPC_STORE;   8: r[6:0] = OPC_OP_IMM;  9: r[6:0] = OPC_OP;
      10: r[6:0] = OPC_FENCE;  11: r[6:0] = OPC_SYSTEM;
      default: ;
    endcase
    r[11:7]  = 5'($urandom_range(0, 7));
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    return r;
  endfunction

  localparam logic [31:0] ADDI_X1_5 = 32'h0050_0093;

  initial begin
    logic [31:0] lw_x5;
    logic        hold;
    lw_x5 = enc_i(12'd0, 5'd2, 3'b010, 5'd5, OPC_LOAD);

    // Power-on reset
    #1 reset_n = 1'b0;
    m = rst_exp();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    chk("rst_pc", id_ex_pc, RST_PC);
    reset_n = 1'b1;

    // ADDI x1, x0, 5
    issue(ADDI_X1_5, 32'h100);
    step();
    chk("addi_imm", id_ex_imm, 32'd5);
    chk("addi_alu", id_ex_alu_op, 4'(ALU_ADD));
    chk("addi_rd", id_ex_rd, 5'd1);
    chk("addi_rw", id_ex_reg_write, 1'b1);

    // Writeback bypass, then x0 never bypasses
    rs1_data = 32'h11; rs2_data = 32'h22;
    wb_wr_en = 1'b1; wb_rd_addr = 5'd3; wb_wr_data = 32'hABCD;
    issue(enc_r(7'd0, 5'd3, 5'd3, 3'b000, 5'd4), 32'h104);
    step();
    chk("byp_rs1", id_ex_rs1_val, 32'hABCD);
    chk("byp_rs2", id_ex_rs2_val, 32'hABCD);
    wb_rd_addr = 5'd0;
    issue(enc_r(7'd0, 5'd0, 5'd0, 3'b000, 5'd4), 32'h108);
    step();
    chk("nobyp_rs1", id_ex_rs1_val, 32'h11);
    chk("nobyp_rs2", id_ex_rs2_val, 32'h22);
    wb_wr_en = 1'b0;

    // Load-use on rs1, one bubble, then capture
    issue(lw_x5, 32'h10C); step();
    issue(enc_r(7'd0, 5'd1, 5'd5, 3'b000, 5'd6), 32'h110);
    #1 chk("lu_stall", stall_o, 1'b1);
    step();
    chk("lu_bubble_v", id_ex_valid, 1'b0);
    chk("lu_bubble_rw", id_ex_reg_write, 1'b0);
    #1 chk("lu_release", stall_o, 1'b0);
    step();
    chk("lu_add_v", id_ex_valid, 1'b1);
    chk("lu_add_rd", id_ex_rd, 5'd6);
    // Store data dependency also stalls
    issue(lw_x5, 32'h114); step();
    issue(enc_s(12'd0, 5'd5, 5'd1), 32'h118);
    #1 chk("lu_sw_stall", stall_o, 1'b1);
    step(); step();
    chk("sw_mw", id_ex_mem_write, 1'b1);
    // LUI does not read rs1
    issue(lw_x5, 32'h11C); step();
    issue({20'h12345, 5'd5, OPC_LUI}, 32'h120);
    #1 chk("lui_nostall", stall_o, 1'b0);
    step();

    // Immediates
    issue(enc_b(-13'sd8, 5'd2, 5'd1), 32'h124); step();
    chk("beq_imm", id_ex_imm, 32'hFFFF_FFF8);
    issue(enc_j(21'd2048, 5'd1), 32'h128); step();
    chk("jal_imm", id_ex_imm, 32'h0000_0800);
    chk("jal_wb", id_ex_wb_sel, 2'(WB_PC4));
    chk("jal_spc", id_ex_alu_src_pc, 1'b1);
    issue({20'hFFFFF, 5'd7, OPC_LUI}, 32'h12C); step();
    chk("lui_imm", id_ex_imm, 32'hFFFF_F000);

    // Flush beats load-use and ex_stall
    issue(lw_x5, 32'h130); step();
    issue(enc_r(7'd0, 5'd1, 5'd5, 3'b000, 5'd6), 32'h134);
    ex_stall_i = 1'b1; flush_i = 1'b1;
    #1 chk("flush_stall", stall_o, 1'b0);
    step();
    chk("flush_v", id_ex_valid, 1'b0);
    ex_stall_i = 1'b0;
    issue(enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd6), 32'h138);
    step();
    chk("flush_add_v", id_ex_valid, 1'b0);
    flush_i = 1'b0;

    // Hold for three cycles
    issue(enc_i(12'd77, 5'd1, 3'b000, 5'd9, OPC_OP_IMM), 32'h200); step();
    ex_stall_i = 1'b1;
    issue(enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd10), 32'h300);
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold_stall", stall_o, 1'b1);
      step();
      chk("hold_pc", id_ex_pc, 32'h200);
      chk("hold_imm", id_ex_imm, 32'd77);
    end
    ex_stall_i = 1'b0;

    // Illegal opcode
    issue({25'h000_0183, 7'h7F}, 32'h304); step();
    chk("ill_flag", id_ex_illegal, 1'b1);
    chk("ill_rw", id_ex_reg_write, 1'b0);
    chk("ill_mw", id_ex_mem_write, 1'b0);

    // Randomized traffic; IF/ID holds its instruction while stalled
    hold = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!hold) begin
        if_id_valid = ($urandom_range(0, 99) < 85);
        if_id_instr = rand_instr();
        if_id_pc    = $urandom & 32'hFFFF_FFFC;
      end
      rs1_data   = $urandom;
      rs2_data   = $urandom;
      wb_wr_en   = $urandom_range(0, 1) == 1;
      wb_rd_addr = 5'($urandom_range(0, 7));
      wb_wr_data = $urandom;
      ex_stall_i = ($urandom_range(0, 99) < 15);
      flush_i    = ($urandom_range(0, 99) < 10);
      hold = (ex_stall_i || ref_load_use()) && !flush_i;
      step();
    end

    // Reset asserted mid-stream, between clock edges
    reset_n = 1'b0;
    ex_stall_i = 1'b0; flush_i = 1'b0;
    #1;
    m = rst_exp();
    compare_all();
    chk("mid_rst_pc", id_ex_pc, RST_PC);
    chk("mid_rst_imm", id_ex_imm, 32'd0);
    chk("mid_rst_alu", id_ex_alu_op, 4'd0);
    chk("mid_rst_stall", stall_o, 1'b0);
    @(posedge clk); #1;
    chk("mid_rst_hold_v", id_ex_valid, 1'b0);
    reset_n = 1'b1;
    wb_wr_en = 1'b0;
    issue(ADDI_X1_5, 32'h400);
    step();
    chk("post_rst_imm", id_ex_imm, 32'd5);
    chk("post_rst_src_imm", id_ex_alu_src_imm, 1'b1);
    chk("post_rst_rd", id_ex_rd, 5'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
Instruction-decode stage of the RV32I 5-stage pipeline. It drives the register file read addresses and consumes the returned rs1/rs2 data. It bypasses a same-cycle writeback, decodes control and immediates, and detects load-use hazards. Results are registered into the ID/EX pipeline register that feeds the execute stage.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
RESET_PC, 32'h0000_0000, reset value of id_ex_pc.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
if_id_valid  in  1  IF/ID holds a valid instruction
if_id_instr  in  32  instruction word
if_id_pc  in  32  instruction PC
rs1_addr  out  5  register file read address 1 = if_id_instr[19:15], combinational
rs2_addr  out  5  register file read address 2 = if_id_instr[24:20], combinational
rs1_data  in  32  register file read data 1
rs2_data  in  32  register file read data 2
wb_wr_en  in  1  writeback write enable (same signal as the register file write enable)
wb_rd_addr  in  5  writeback destination
wb_wr_data  in  32  writeback data
ex_stall_i  in  1  downstream hold
flush_i  in  1  redirect from EX (taken branch/jump): kill ID contents
stall_o  out  1  hold PC and IF/ID, combinational
id_ex_valid  out  1  ID/EX slot valid
id_ex_pc  out  32  registered PC
id_ex_rs1_val  out  32  operand A (bypassed)
id_ex_rs2_val  out  32  operand B (bypassed)
id_ex_imm  out  32  sign-extended immediate
id_ex_rs1_addr  out  5  for EX forwarding
id_ex_rs2_addr  out  5  for EX forwarding
id_ex_rd  out  5  destination register
id_ex_funct3  out  3  instr[14:12]
id_ex_alu_op  out  4  alu_op_e
id_ex_alu_src_pc  out  1  ALU A = PC (AUIPC, JAL)
id_ex_alu_src_imm  out  1  ALU B = imm
id_ex_mem_read  out  1  load
id_ex_mem_write  out  1  store
id_ex_reg_write  out  1  writes rd; forced 0 when rd = x0
id_ex_wb_sel  out  2  wb_sel_e: ALU = 0, MEM = 1, PC4 = 2
id_ex_branch  out  1  conditional branch
id_ex_jal  out  1  JAL
id_ex_jalr  out  1  JALR
id_ex_illegal  out  1  unknown opcode

Behaviour:
- Reset (asynchronous, reset_n = 0): every id_ex_* output is 0, except id_ex_pc = RESET_PC. Registers stay in reset while reset_n is low and take effect on entry, including mid-instruction. The first capture happens on the first clock edge after deassertion.
- Bypass: the register file writes on the edge, so a same-cycle read returns stale data.
  - rs1 operand = wb_wr_data if wb_wr_en && wb_rd_addr != 0 && wb_rd_addr == rs1_addr; otherwise rs1_data.
  - rs2 is handled identically.
  - Address x0 never bypasses.
- Decode:
  - Opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - FENCE and SYSTEM decode as a NOP: valid, all control fields 0.
  - Any other opcode sets illegal = 1 with reg_write = 0 and mem_read/mem_write = 0.
  - Immediate formats I/S/B/U/J follow the RV32I encoding. B and J immediates have bit 0 = 0. U immediate = instr[31:12] followed by 12 zero bits.
  - OP vs OP-IMM: SUB and SRA are selected by instr[30]. For OP-IMM, instr[30] is honoured only when funct3 = 101.
- Use flags:
  - rs1 is used by JALR, BRANCH, LOAD, STORE, OP-IMM and OP.
  - rs2 is used by BRANCH, STORE and OP.
- Load-use: load_use = if_id_valid && id_ex_valid && id_ex_mem_read && id_ex_rd != 0 && ((rs1 used && id_ex_rd == rs1_addr) || (rs2 used && id_ex_rd == rs2_addr)).
- stall_o = (ex_stall_i || load_use) && !flush_i.
- Register update priority, one rule per edge:
  1. flush_i: id_ex_valid <= 0 (flush wins over everything else).
  2. ex_stall_i: hold all id_ex_* registers.
  3. load_use: id_ex_valid <= 0 (bubble). The datapath fields may update but are don't-care.
  4. Otherwise: capture the decode; id_ex_valid <= if_id_valid.
- Invalid slot: when id_ex_valid = 0, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_branch, id_ex_jal and id_ex_jalr are all 0, so a bubble has no side effects.
- Latency: one cycle from IF/ID to ID/EX. Throughput is one instruction per cycle when there are no hazards.

Decomposition:
- Package riscv_pkg:
  - opcode constants;
  - alu_op_e (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB);
  - wb_sel_e;
  - imm_type_e (I, S, B, U, J, NONE);
  - a ctrl_t struct bundling the control fields.
- Sub-module decode_ctrl: purely combinational; takes the instruction and returns ctrl_t, imm_type, rs1/rs2 use flags and the illegal flag.
- Immediate generation, bypass, hazard logic and the pipeline register live in id_stage.

Test Plan:
- Reset: reset_n = 0 mid-stream → all id_ex_* = 0, id_ex_pc = RESET_PC, stall_o = 0. Release, then ADDI x1, x0, 5 → next edge id_ex_imm = 5, alu_op = ADD, alu_src_imm = 1, reg_write = 1, rd = 1.
- WB bypass: rs1_data = 32'h11 stale while wb_wr_en = 1, wb_rd_addr = 3, wb_wr_data = 32'hABCD; ADD x4, x3, x3 → id_ex_rs1_val = id_ex_rs2_val = 32'hABCD. Repeat with wb_rd_addr = 0 → no bypass.
- Load-use: LW x5, 0(x2) followed by ADD x6, x5, x1 → stall_o = 1 for one cycle, one bubble (valid = 0, reg_write = 0), then ADD captured. The same sequence with SW x5 → stall; LUI x5 after LW x5 → no stall (rs1 unused).
- Immediates: BEQ with offset -8 → id_ex_imm = 32'hFFFF_FFF8. JAL with offset +2048 → 32'h0000_0800, wb_sel = PC4, alu_src_pc = 1. LUI 0xFFFFF → 32'hFFFF_F000.
- Flush priority: flush_i = 1 while load_use = 1 and ex_stall_i = 1 → stall_o = 0, id_ex_valid = 0 next cycle. Flush alone kills a valid ADD.
- Hold and illegal: ex_stall_i = 1 for 3 cycles → id_ex_* unchanged and stall_o = 1. Opcode 7'b1111111 → id_ex_illegal = 1, reg_write = 0, mem_write = 0.
